// File: rtl/alt_vipvfr131_prc_read_cmd_gen.sv
// ============================================================================
// Module  : alt_vipvfr131_prc_read_cmd_gen
// Brief   : Frame read-command generator. Walks a frame line by line and issues
//           read bursts of up to MAX_BURST words to a read master.
// Option  : define ALT_VIPVFR131_CMD_GEN_4K_SPLIT_EN to stop bursts at 4 KB boundaries
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alt_vipvfr131_prc_read_cmd_gen #(
    parameter int ADDR_WIDTH                     = 32,
    parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
    parameter int MAX_BURST                      = 32,
    parameter int BYTES_PER_WORD                 = 4,
    parameter int COUNT_WIDTH                    = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      go,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [COUNT_WIDTH-1:0]                    words_per_line,
    input  logic [COUNT_WIDTH-1:0]                    lines,
    input  logic [ADDR_WIDTH-1:0]                     line_stride,
    output logic                                      busy,
    output logic                                      done,
    output logic [ADDR_WIDTH-1:0]                     cmd_addr,
    output logic                                      cmd_write_instead_of_read,
    output logic                                      cmd_burst_instead_of_single_op,
    output logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] cmd_length_of_burst,
    output logic                                      cmd,
    input  logic                                      stall
);

    localparam int LW        = MAX_BURST_LENGTH_REQUIREDWIDTH;
    localparam int BPW_SHIFT = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic                    cmd_nxt;
    logic [ADDR_WIDTH-1:0]   cmd_addr_nxt;
    logic [LW-1:0]           len_nxt;
    logic                    burst_nxt;
    logic [ADDR_WIDTH-1:0]   line_addr, line_addr_nxt;
    logic [COUNT_WIDTH-1:0]  words_left, words_left_nxt;
    logic [COUNT_WIDTH-1:0]  lines_left, lines_left_nxt;
    logic [COUNT_WIDTH-1:0]  cfg_words, cfg_words_nxt;
    logic [ADDR_WIDTH-1:0]   cfg_stride, cfg_stride_nxt;

    logic [COUNT_WIDTH-1:0]  wl_after;
    logic                    line_end;
    logic [ADDR_WIDTH-1:0]   next_line_addr;
    logic [COUNT_WIDTH-1:0]  next_wl;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [31:0]             first_cap;
    logic [31:0]             next_cap;
    logic [LW-1:0]           first_len;
    logic [LW-1:0]           next_len;

    function automatic logic [LW-1:0] burst_len(input logic [COUNT_WIDTH-1:0] wl,
                                                input logic [31:0]            cap);
        logic [31:0] n;
        n = 32'(wl);
        if (n > cap) n = cap;
        return n[LW-1:0];
    endfunction

`ifdef ALT_VIPVFR131_CMD_GEN_4K_SPLIT_EN
    // Words remaining before the next 4 KB page, clipped to MAX_BURST.
    function automatic logic [31:0] word_cap(input logic [11:0] a);
        logic [12:0] room;
        logic [31:0] w;
        room = 13'h1000 - {1'b0, a};
        w    = 32'(room >> BPW_SHIFT);
        if (w > 32'(MAX_BURST)) w = 32'(MAX_BURST);
        return w;
    endfunction

    assign first_cap = word_cap(base_addr[11:0]);
    assign next_cap  = word_cap(next_addr[11:0]);
`else
    assign first_cap = 32'(MAX_BURST);
    assign next_cap  = 32'(MAX_BURST);
`endif

    // words_left counts the words of the current line still owed, including
    // the burst currently presented on cmd_*.
    assign wl_after       = words_left - COUNT_WIDTH'(cmd_length_of_burst);
    assign line_end       = (wl_after == '0);
    assign next_line_addr = line_end ? line_addr + cfg_stride : line_addr;
    assign next_wl        = line_end ? cfg_words : wl_after;
    assign next_addr      = next_line_addr + (ADDR_WIDTH'(cfg_words - next_wl) << BPW_SHIFT);
    assign next_len       = burst_len(next_wl, next_cap);
    assign first_len      = burst_len(words_per_line, first_cap);

    always_comb begin
        state_nxt      = state;
        cmd_nxt        = cmd;
        cmd_addr_nxt   = cmd_addr;
        len_nxt        = cmd_length_of_burst;
        line_addr_nxt  = line_addr;
        words_left_nxt = words_left;
        lines_left_nxt = lines_left;
        cfg_words_nxt  = cfg_words;
        cfg_stride_nxt = cfg_stride;

        case (state)
            S_IDLE: begin
                if (go) begin
                    cfg_words_nxt  = words_per_line;
                    cfg_stride_nxt = line_stride;
                    line_addr_nxt  = base_addr;
                    words_left_nxt = words_per_line;
                    lines_left_nxt = lines;
                    if (words_per_line == '0 || lines == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt    = S_ISSUE;
                        cmd_nxt      = 1'b1;
                        cmd_addr_nxt = base_addr;
                        len_nxt      = first_len;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd && !stall) begin
                    if (line_end && lines_left <= COUNT_WIDTH'(1)) begin
                        state_nxt      = S_DONE;
                        cmd_nxt        = 1'b0;
                        words_left_nxt = '0;
                        lines_left_nxt = '0;
                    end else begin
                        cmd_nxt        = 1'b1;
                        cmd_addr_nxt   = next_addr;
                        len_nxt        = next_len;
                        line_addr_nxt  = next_line_addr;
                        words_left_nxt = next_wl;
                        if (line_end) lines_left_nxt = lines_left - COUNT_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cmd_nxt   = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
                cmd_nxt   = 1'b0;
            end
        endcase

        burst_nxt = (len_nxt > LW'(1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd                            <= 1'b0;
            cmd_addr                       <= '0;
            cmd_length_of_burst            <= '0;
            cmd_burst_instead_of_single_op <= 1'b0;
            line_addr                      <= '0;
            words_left                     <= '0;
            lines_left                     <= '0;
            cfg_words                      <= '0;
            cfg_stride                     <= '0;
        end else begin
            cmd                            <= cmd_nxt;
            cmd_addr                       <= cmd_addr_nxt;
            cmd_length_of_burst            <= len_nxt;
            cmd_burst_instead_of_single_op <= burst_nxt;
            line_addr                      <= line_addr_nxt;
            words_left                     <= words_left_nxt;
            lines_left                     <= lines_left_nxt;
            cfg_words                      <= cfg_words_nxt;
            cfg_stride                     <= cfg_stride_nxt;
        end
    end

    assign busy                      = (state == S_ISSUE);
    assign done                      = (state == S_DONE);
    assign cmd_write_instead_of_read = 1'b0;

endmodule

`default_nettype wire

// File: doc/alt_vipvfr131_prc_read_cmd_gen.md
ALT_VIPVFR131_PRC_READ_CMD_GEN -- requirements
Module: alt_vipvfr131_prc_read_cmd_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of cmd_addr, base_addr and line_stride.
REQ-002 SHALL have parameter MAX_BURST_LENGTH_REQUIREDWIDTH, default 11, width of cmd_length_of_burst.
REQ-003 SHALL have parameter MAX_BURST, default 32, largest burst length issued, in words, range 1..2^MAX_BURST_LENGTH_REQUIREDWIDTH-1.
REQ-004 SHALL have parameter BYTES_PER_WORD, default 4, a power of two, byte increment per memory word.
REQ-005 SHALL have parameter COUNT_WIDTH, default 16, width of words_per_line and lines.
REQ-006 clock  input  1  single clock for all logic.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 go  input  1  start-of-frame pulse, sampled only in IDLE.
REQ-009 base_addr  input  ADDR_WIDTH  frame start byte address.
REQ-010 words_per_line  input  COUNT_WIDTH  words per line.
REQ-011 lines  input  COUNT_WIDTH  lines per frame.
REQ-012 line_stride  input  ADDR_WIDTH  byte distance between line starts.
REQ-013 busy  output  1  high from the cycle after go is accepted until done.
REQ-014 done  output  1  one-cycle end-of-frame pulse.
REQ-015 cmd_addr  output  ADDR_WIDTH  burst start byte address.
REQ-016 cmd_write_instead_of_read  output  1  constant 0.
REQ-017 cmd_burst_instead_of_single_op  output  1  1 when cmd_length_of_burst > 1, else 0.
REQ-018 cmd_length_of_burst  output  MAX_BURST_LENGTH_REQUIREDWIDTH  burst length in words.
REQ-019 cmd  output  1  command valid.
REQ-020 stall  input  1  read-master backpressure; a command transfers on a cycle with cmd=1 and stall=0.

Function
REQ-021 SHALL implement the FSM IDLE -> ISSUE -> DONE -> IDLE.
REQ-022 In IDLE, go=1 SHALL latch all configuration inputs and load line_addr=base_addr, words_left=words_per_line and lines_left=lines, then enter ISSUE on the next cycle.
REQ-023 If go=1 arrives with words_per_line=0 or lines=0, the FSM SHALL enter DONE directly and issue no commands.
REQ-024 In ISSUE, the block SHALL register cmd=1 with cmd_addr = line_addr + (words_per_line - words_left)*BYTES_PER_WORD and cmd_length_of_burst = min(words_left, MAX_BURST).
REQ-025 The first cmd SHALL be high on the cycle after go was accepted.
REQ-026 While stall=1, all cmd_* outputs SHALL hold stable and cmd SHALL stay high.
REQ-027 On each transfer, words_left SHALL decrement by the issued length.
REQ-028 When words_left reaches 0 and lines_left > 1, the block SHALL add line_stride to line_addr modulo 2^ADDR_WIDTH, reload words_left, and decrement lines_left.
REQ-029 Back-to-back transfers SHALL be possible with no idle cycle, including across line boundaries.
REQ-030 Transfer of the last burst of the last line SHALL drop cmd in the next cycle and enter DONE.
REQ-031 DONE SHALL last exactly one cycle, asserting done=1 and busy=0, then return to IDLE.
REQ-032 go received outside IDLE SHALL be ignored.
REQ-033 Configuration inputs SHALL be ignored except in the go cycle.

Reset
REQ-034 reset SHALL force IDLE with busy=0, done=0, cmd=0, cmd_addr=0, cmd_length_of_burst=0, cmd_burst_instead_of_single_op=0 and all counters 0.
REQ-035 reset mid-frame SHALL abandon the frame with no further commands; a pending stalled command is dropped.
REQ-036 reset SHALL take priority over go in the same cycle.

Configuration
REQ-037 Macro ALT_VIPVFR131_CMD_GEN_4K_SPLIT_EN SHALL control 4 KB burst splitting.
REQ-038 With ALT_VIPVFR131_CMD_GEN_4K_SPLIT_EN defined, burst length SHALL be min(words_left, MAX_BURST, (4096 - cmd_addr[11:0])/BYTES_PER_WORD), so no burst crosses a 4096-byte boundary.
REQ-039 Without ALT_VIPVFR131_CMD_GEN_4K_SPLIT_EN, the 4 KB term SHALL be absent.

Verification
REQ-040 Scenario: base=0x1000, words=80, lines=2, stride=0x400, stall=0 -> bursts (0x1000,32), (0x1080,32), (0x1100,16), (0x1400,32), (0x1480,32), (0x1500,16); done one cycle after the last transfer.
REQ-041 Scenario: words=1, lines=1 -> single command with length=1 and cmd_burst_instead_of_single_op=0.
REQ-042 Scenario: stall held high 5 cycles during the second burst -> outputs stable across all 5 cycles; no duplicate or lost burst.
REQ-043 Scenario: lines=0 -> no cmd; done pulse 1 cycle after go; go while busy is ignored.
REQ-044 Scenario: reset asserted during the third burst with stall=1 -> next cycle cmd=0 and busy=0; a new go restarts cleanly from its base_addr.
REQ-045 Scenario (4K_SPLIT_EN): base=0x0FF0, words=32 -> bursts (0x0FF0,4) then (0x1000,28); without the macro -> a single (0x0FF0,32).
